// File: rtl/saa_capture_win.sv
// SAA7111 VPO capture front-end: window crop, power-of-two decimation, framed
// pixel stream, and line/frame measurement with lock indication.
module saa_capture_win #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 11,
  parameter int unsigned FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              href,
  input  logic              vref,
  input  logic [DATA_W-1:0] vpo,
  input  logic              enable,
  input  logic [CNT_W-1:0]  x_start,
  input  logic [CNT_W-1:0]  x_end,
  input  logic [CNT_W-1:0]  y_start,
  input  logic [CNT_W-1:0]  y_end,
  input  logic [1:0]        decim,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [CNT_W-1:0]  line_len,
  output logic [CNT_W-1:0]  line_cnt,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [1:0]        led
);

  localparam int unsigned SW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              href_q, vref_q, href_d, vref_d;
  logic              q_valid, primed;
  logic [DATA_W-1:0] vpo_q;
  logic [CNT_W-1:0]  x_reg, y_reg;
  logic              armed, sof_pend, locked;

  logic              fs, fe, ls, le;
  logic [CNT_W-1:0]  x_cur, y_cur, x_nxt, y_nxt, y_le;
  logic              armed_cur, accept, eol_c, in_x, in_y;
  logic [1:0]        dsh;
  logic [SW-1:0]     step;
  logic [CNT_W-1:0]  mask;

  // Edge detection is gated until the delayed stage-1 copies hold real samples,
  // so a level that is already high when reset releases is not seen as an edge.
  always_comb begin
    fs        = primed & vref_q & ~vref_d;
    fe        = primed & ~vref_q & vref_d;
    ls        = primed & href_q & ~href_d & vref_q;
    le        = primed & ~href_q & href_d;
    x_cur     = ls ? '0 : x_reg;
    y_cur     = fs ? '0 : y_reg;
    armed_cur = fs ? enable : armed;
    dsh       = (decim == 2'd3) ? 2'd2 : decim;
    step      = SW'(1) << dsh;
    mask      = CNT_W'(step - SW'(1));
    in_x      = (x_cur >= x_start) && (x_cur <= x_end);
    in_y      = (y_cur >= y_start) && (y_cur <= y_end);
    accept    = armed_cur & href_q & vref_q & in_x & in_y &
                ((x_cur & mask) == '0) & ((y_cur & mask) == '0);
    eol_c     = ({1'b0, x_cur} + step) > {1'b0, x_end};
    x_nxt     = x_reg;
    if (href_q) begin
      x_nxt = (x_cur == CNT_MAX) ? x_cur : x_cur + CNT_W'(1);
    end
    y_le      = (y_reg == CNT_MAX) ? y_reg : y_reg + CNT_W'(1);
    y_nxt     = y_reg;
    if (fs) begin
      y_nxt = '0;
    end else if (le && vref_d) begin
      y_nxt = y_le;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_q    <= 1'b0;
      vref_q    <= 1'b0;
      href_d    <= 1'b0;
      vref_d    <= 1'b0;
      vpo_q     <= '0;
      q_valid   <= 1'b0;
      primed    <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      armed     <= 1'b0;
      sof_pend  <= 1'b0;
      locked    <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      line_len  <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      href_q    <= href;
      vref_q    <= vref;
      vpo_q     <= vpo;
      href_d    <= href_q;
      vref_d    <= vref_q;
      q_valid   <= 1'b1;
      primed    <= q_valid;
      x_reg     <= x_nxt;
      y_reg     <= y_nxt;
      armed     <= armed_cur;
      sof_pend  <= (fs | sof_pend) & ~accept;
      pix_valid <= accept;
      pix_sof   <= accept & (fs | sof_pend);
      pix_eol   <= accept & eol_c;
      if (accept) begin
        pix_data <= vpo_q;
      end
      if (le) begin
        line_len <= x_reg;
      end
      // y_nxt already carries an end-of-line increment landing on the same cycle
      if (fe) begin
        line_cnt  <= y_nxt;
        frame_cnt <= frame_cnt + FCNT_W'(1);
        locked    <= (y_nxt == line_cnt) && (y_nxt != '0);
      end
    end
  end

  assign led = {locked, frame_cnt[4]};

endmodule

// File: tb/tb_saa_capture_win.sv
// Directed bench for saa_capture_win: a pixel-coordinate model predicts every
// output cycle; per-frame totals and measurements are pinned by literals.
module tb_saa_capture_win;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        href = 1'b0;
  logic        vref = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] vpo = '0;
  logic [10:0] x_start = 11'd0, x_end = 11'd15, y_start = 11'd0, y_end = 11'd7;
  logic [1:0]  decim = 2'd0;
  logic [15:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol;
  logic [10:0] line_len, line_cnt;
  logic [7:0]  frame_cnt;
  logic [1:0]  led;

  saa_capture_win #(.DATA_W(16), .CNT_W(11), .FCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .href(href), .vref(vref), .vpo(vpo),
    .enable(enable), .x_start(x_start), .x_end(x_end), .y_start(y_start),
    .y_end(y_end), .decim(decim), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .line_len(line_len),
    .line_cnt(line_cnt), .frame_cnt(frame_cnt), .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [15:0] data;
    logic        sof;
    logic        eol;
  } exp_t;

  exp_t exp_q[$];
  int   ec = 0;
  int   n_cmp = 0, n_bad = 0;
  int   tot_valid = 0, tot_eol = 0, tot_sof = 0;
  bit   m_armed = 1'b0, m_sof_pend = 1'b0, m_locked = 1'b0, lc_known = 1'b1;
  int   m_frames = 0, m_prev = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_flags"}, 32'({pix_valid, pix_sof, pix_eol, led}), 0);
    chk({nm, "_data"}, 32'(pix_data), 0);
    chk({nm, "_meas"}, 32'({line_len, line_cnt, frame_cnt}), 0);
  endtask

  initial forever begin
    @(posedge clk);
    ec++;
  end

  // Per-cycle compare of the pixel stream against the model queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() > 0 && exp_q[0].tag == ec) begin
          e = exp_q.pop_front();
          chk("pix_valid", 32'(pix_valid), 1);
          chk("pix_data", 32'(pix_data), 32'(e.data));
          chk("pix_sof", 32'(pix_sof), 32'(e.sof));
          chk("pix_eol", 32'(pix_eol), 32'(e.eol));
        end else begin
          chk("pix_idle", 32'(pix_valid), 0);
        end
        if (pix_valid) begin
          tot_valid++;
          if (pix_eol) tot_eol++;
          if (pix_sof) tot_sof++;
        end
      end
    end
  end

  task automatic model_pixel(input int x, input int y);
    exp_t e;
    int   st;
    st = (decim == 2'd3) ? 4 : (1 << decim);
    if (m_armed && x >= int'(x_start) && x <= int'(x_end) &&
        y >= int'(y_start) && y <= int'(y_end) && (x % st) == 0 && (y % st) == 0) begin
      e.tag  = ec + 2;
      e.data = 16'(x + 16 * y);
      e.sof  = m_sof_pend;
      e.eol  = (x + st) > int'(x_end);
      exp_q.push_back(e);
      m_sof_pend = 1'b0;
    end
  endtask

  task automatic drive(input logic h, input logic v, input int x, input int y);
    @(posedge clk);
    #1;
    href = h;
    vref = v;
    vpo  = 16'(x + 16 * y);
    if (h && v) model_pixel(x, y);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    exp_q.delete();
    m_armed = 1'b0;
    m_sof_pend = 1'b0;
    m_frames = 0;
    m_locked = 1'b0;
    #1 chk_zero("rst_async");
    @(posedge clk);
    #2 chk_zero("rst_hold");
    #2 rst_n = 1'b1;
  endtask

  task automatic frame(input int nl, input int np, input int pre, input int post,
                       input int drop_ln, input int rise_ln, input int rst_ln,
                       output int nv, output int ne, output int ns);
    int v0, e0, s0;
    bit rst_fr;
    rst_fr = 1'b0;
    v0 = tot_valid; e0 = tot_eol; s0 = tot_sof;
    m_armed = enable;
    m_sof_pend = 1'b1;
    for (int i = 0; i < pre; i++) drive(1'b0, 1'b1, 0, 0);
    for (int y = 0; y < nl; y++) begin
      if (y == drop_ln) enable = 1'b0;
      if (y == rise_ln) enable = 1'b1;
      for (int x = 0; x < np; x++) begin
        drive(1'b1, 1'b1, x, y);
        if (y == rst_ln && x == 7) begin
          do_reset();
          rst_fr = 1'b1;
        end
      end
      for (int i = 0; i < ((y < nl - 1) ? 3 : post); i++) drive(1'b0, 1'b1, 0, 0);
    end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 0, 0);
    m_frames++;
    if (!rst_fr) begin
      chk("line_len", 32'(line_len), np);
      chk("line_cnt", 32'(line_cnt), nl);
      if (lc_known) begin
        m_locked = (nl == m_prev) && (nl != 0);
        chk("locked", 32'(led[1]), 32'(m_locked));
      end
      m_prev = nl;
      lc_known = 1'b1;
    end else begin
      lc_known = 1'b0;
    end
    chk("frame_cnt", 32'(frame_cnt), m_frames % 256);
    chk("led0", 32'(led[0]), (m_frames >> 4) & 1);
    nv = tot_valid - v0;
    ne = tot_eol - e0;
    ns = tot_sof - s0;
  endtask

  initial begin
    int nv, ne, ns, f0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // full window, three identical frames then a short one
    frame(8, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("full_valid", nv, 128); chk("full_eol", ne, 8); chk("full_sof", ns, 1);
    chk("lock_fe1", 32'(led[1]), 0);
    frame(8, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("lock_fe2", 32'(led[1]), 1);
    frame(8, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("lock_fe3", 32'(led[1]), 1);
    frame(7, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("lock_short", 32'(led[1]), 0); chk("short_lines", 32'(line_cnt), 7);

    // crop
    x_start = 11'd4; x_end = 11'd9; y_start = 11'd2; y_end = 11'd5;
    frame(8, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("crop_valid", nv, 24); chk("crop_eol", ne, 4); chk("crop_sof", ns, 1);

    // decimation
    x_start = 11'd0; x_end = 11'd15; y_start = 11'd0; y_end = 11'd7;
    decim = 2'd1;
    frame(8, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("dec1_valid", nv, 32); chk("dec1_eol", ne, 4);
    decim = 2'd3;
    frame(8, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("dec3_valid", nv, 8); chk("dec3_eol", ne, 2);
    decim = 2'd2;
    frame(8, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("dec2_valid", nv, 8);
    decim = 2'd0;

    // arming: drop mid-frame 1, rise mid-frame 2
    frame(8, 16, 2, 3, 3, -1, -1, nv, ne, ns);
    chk("arm_f1", nv, 128);
    frame(8, 16, 2, 3, -1, 4, -1, nv, ne, ns);
    chk("arm_f2", nv, 0);
    frame(8, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("arm_f3", nv, 128);

    // inverted window produces nothing
    x_start = 11'd10; x_end = 11'd5;
    frame(8, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("empty_valid", nv, 0); chk("empty_sof", ns, 0);
    x_start = 11'd0; x_end = 11'd15;

    // FS with LS, LE with FE
    frame(8, 16, 0, 0, -1, -1, -1, nv, ne, ns);
    chk("coinc_valid", nv, 128); chk("coinc_sof", ns, 1); chk("coinc_lines", 32'(line_cnt), 8);

    // reset mid-line, then resume
    frame(8, 16, 2, 3, -1, -1, 2, nv, ne, ns);
    frame(8, 16, 2, 3, -1, -1, -1, nv, ne, ns);
    chk("post_rst_valid", nv, 128); chk("post_rst_sof", ns, 1);

    // frame counter wrap
    f0 = m_frames % 256;
    for (int i = 0; i < 256; i++) frame(1, 2, 1, 1, -1, -1, -1, nv, ne, ns);
    chk("fcnt_wrap", 32'(frame_cnt), f0);
    chk("tiny_lock", 32'(led[1]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/saa_capture_win.md
# saa_capture_win

Parametrised video-port capture front-end for the SAA7111 decoder, successor to the fixed 16-bit RGB capture block. It samples the VPO bus with HREF/VREF on the pixel clock (LLC) and crops a runtime-programmable window. It applies power-of-two decimation and emits a framed pixel stream (valid/sof/eol) to downstream buffering. It also measures line length, lines per frame and frame count, and drives the two status LEDs.

## Interface
Parameters:
- DATA_W, 16, VPO bus width (8 or 16 in use)
- CNT_W, 11, width of x/y counters and measurement outputs
- FCNT_W, 8, frame counter width (must be at least 5)

Ports:
- clk  in  1  pixel clock (LLC); one clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- href  in  1  horizontal reference; high during active pixels of a line
- vref  in  1  vertical reference; high during active lines of a frame
- vpo  in  DATA_W  pixel data
- enable  in  1  capture enable; sampled only at frame start
- x_start, x_end  in  CNT_W  inclusive horizontal crop bounds
- y_start, y_end  in  CNT_W  inclusive vertical crop bounds
- decim  in  2  decimation: 0 → 1:1, 1 → 1:2, 2 → 1:4, 3 treated as 2 (both axes)
- pix_data  out  DATA_W  captured pixel
- pix_valid  out  1  pix_data valid this cycle
- pix_sof  out  1  first accepted pixel of frame (with pix_valid)
- pix_eol  out  1  last accepted pixel of line (with pix_valid)
- line_len  out  CNT_W  pixel count of last completed line
- line_cnt  out  CNT_W  line count of last completed frame
- frame_cnt  out  FCNT_W  completed frames, wraps to 0
- led  out  2  led[0] = frame_cnt[4]; led[1] = locked

## Operation
- Stage 1 registers href, vref and vpo. All edge detection uses stage-1 values and their one-cycle-delayed copies.
- Frame start (FS) is a vref rising edge. Frame end (FE) is a vref falling edge. Line start (LS) is an href rising edge while vref is high. Line end (LE) is an href falling edge.
- x counter:
  - cleared to 0 on LS; the first href-high pixel has x=0.
  - increments on each href-high cycle.
  - saturates at 2^CNT_W-1 and never wraps.
- y counter:
  - cleared on FS.
  - the first line has y=0; y increments on each LE while vref is high.
  - saturates like x.
- Arming: on FS, `armed <= enable`. Deasserting enable mid-frame does not truncate the current frame.
- A pixel is accepted when all of the following hold:
  - armed, href high and vref high (stage 1)
  - x_start ≤ x ≤ x_end and y_start ≤ y ≤ y_end
  - the low decim bits of both x and y are zero
- If x_start > x_end or y_start > y_end, no pixel is accepted; this is not an error.
- pix_sof is asserted on the first accepted pixel after FS, once per frame.
- pix_eol is asserted on an accepted pixel when x + 2^decim > x_end. If href falls before x_end, that line produces no eol.
- Measurements:
  - on LE, line_len <= final x count.
  - on FE, line_cnt <= y.
  - on FE, frame_cnt increments.
- locked:
  - on FE, if the new line_cnt equals the previous line_cnt and is nonzero, locked is set; otherwise it is cleared.
  - locked is evaluated only at FE.
- Simultaneous events:
  - FS and LS in the same cycle: the y clear takes priority, so the line is y=0.
  - LE and FE in the same cycle: the y increment happens before the line_cnt capture, so line_cnt includes that line.

## Timing
- Latency: vpo presented before clock edge N appears on pix_data/pix_valid after edge N+1 (2 cycles); no backpressure.
- pix_valid, pix_sof and pix_eol are single-cycle registered pulses. pix_data holds its last value when invalid.
- line_len, line_cnt, frame_cnt and locked update on the cycle after the stage-1 edge detect and remain stable until the next update.
- Reset (asserted at any time, including mid-line) immediately clears:
  - all outputs, counters, armed, locked and pipeline registers to 0.
  - After release, no pixel is accepted until the next FS.
- Configuration inputs are used combinationally. Changing them mid-frame is allowed; the result is defined per pixel.

## Test plan
- Full window: frames of 8 lines × 16 px, enable=1, window 0..15/0..7, decim=0 → 128 valid per frame; one sof on (0,0); 8 eol at x=15; line_len=16, line_cnt=8.
- Crop: window x 4..9, y 2..5 → 24 valid; sof on (4,2); eol at x=9 on y=2..5; pix_data equals vpo pattern x+16·y delayed 2 cycles.
- Decimation: decim=1, full window → 32 valid (even x, even y), eol at x=14; decim=3 gives the same result as decim=2 (8 valid).
- Arming: enable dropped at line 3 of frame 1 → frame 1 completes all 128; frame 2 has 0 valid. Enable rises mid-frame 2 → frame 3 captures.
- Lock/counters: three identical 8-line frames → locked=0 after FE 1 and 1 after FE 2; a 7-line frame clears locked. 256 frames → frame_cnt wraps to 0; led[0] toggles every 16 frames.
- Reset mid-line at x=7 → all outputs 0 next cycle. After release there is no valid output until the next vref rise; then normal capture resumes.
